vga_timing_gen: RTL and testbench

- Generates the horizontal and vertical pixel counters Qh/Qv that feed the tile/font lookup (Posicion_Mosaicos), along with the VGA sync and blanking signals.
- Standard 640x480 @ 60 Hz timing: 800 pixels per line, 525 lines per frame.
- Runs from the 100 MHz system clock with an internal divide-by-4 pixel enable, so Qh advances once every 40 ns.
- Top-level source of all raster coordinates in the display path.

---
 rtl/vga_timing_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// ----------------------------------------------------------------------------
// vga_timing_if
// Bundles the raster timing outputs of vga_timing_gen so that downstream
// consumers (tile/font lookup, colour path) take a single port.
//   pixel_tick   : one-reloj-cycle pixel enable
//   Qh / Qv      : horizontal pixel / vertical line counters
//   hsync/vsync  : active-low sync pulses
//   video_on     : high inside the visible area
//   end_of_frame : one-cycle pulse on the last pixel of a frame
// master = timing generator, slave = consumer.
// ----------------------------------------------------------------------------
interface vga_timing_if;
   logic       pixel_tick;
   logic [9:0] Qh;
   logic [9:0] Qv;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       end_of_frame;

   modport master (
      output pixel_tick, Qh, Qv, hsync, vsync, video_on, end_of_frame
   );

   modport slave (
      input  pixel_tick, Qh, Qv, hsync, vsync, video_on, end_of_frame
   );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator (default 640x480 @ 60 Hz, 800x525 totals).
// A divide-by-DIV counter on the system clock produces the pixel enable;
// Qh/Qv advance on that enable and the sync/blanking flags are registered
// from the decode of the next counter values, so every raster output
// changes on the same edge and is glitch-free.
// Ports:
//   reloj  : system clock, rising edge
//   reset  : synchronous, active-high reset
//   vga    : vga_timing_if.master (pixel_tick, Qh, Qv, hsync, vsync,
//            video_on, end_of_frame)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int DIV       = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic         reloj,
   input  logic         reset,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       qh_q, qh_d;
   logic [9:0]       qv_q, qv_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             tick;

   // Sync pulses are active low inside their window.
   function automatic logic hsync_dec(input logic [9:0] h);
      return !((h >= HS_START) && (h < HS_END));
   endfunction

   function automatic logic vsync_dec(input logic [9:0] v);
      return !((v >= VS_START) && (v < VS_END));
   endfunction

   function automatic logic video_dec(input logic [9:0] h, input logic [9:0] v);
      return (h < H_VIS) && (v < V_VIS);
   endfunction

   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      qh_d      = qh_q;
      qv_d      = qv_q;
      if (tick) begin
         if (qh_q == H_LAST) begin
            qh_d = '0;
            qv_d = (qv_q == V_LAST) ? 10'd0 : qv_q + 10'd1;
         end else begin
            qh_d = qh_q + 10'd1;
         end
      end
      // Decode the position the counters are about to hold, so the
      // registered flags line up with Qh/Qv on the same edge.
      hsync_d    = hsync_dec(qh_d);
      vsync_d    = vsync_dec(qv_d);
      video_on_d = video_dec(qh_d, qv_d);
   end

   always_ff @(posedge reloj) begin
      if (reset) begin
         div_cnt_q  <= '0;
         qh_q       <= '0;
         qv_q       <= '0;
         hsync_q    <= hsync_dec(10'd0);
         vsync_q    <= vsync_dec(10'd0);
         video_on_q <= video_dec(10'd0, 10'd0);
      end else begin
         div_cnt_q  <= div_cnt_d;
         qh_q       <= qh_d;
         qv_q       <= qv_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

   assign vga.pixel_tick   = tick;
   assign vga.Qh           = qh_q;
   assign vga.Qv           = qv_q;
   assign vga.hsync        = hsync_q;
   assign vga.vsync        = vsync_q;
   assign vga.video_on     = video_on_q;
   assign vga.end_of_frame = tick && (qh_q == H_LAST) && (qv_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clock and reset: u_a uses the full 640x480 timing,
// u_b a reduced raster (16x10 totals, DIV=4) so a whole frame fits in a
// short run. Expected samples are keyed by (reset phase, cycle number),
// where cycle 1 is the cycle following the last edge that sampled reset.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   vga_timing_if a_if ();
   vga_timing_if b_if ();

   vga_timing_gen u_a (
      .reloj (clk),
      .reset (rst),
      .vga   (a_if)
   );

   vga_timing_gen #(
      .DIV(4), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_b (
      .reloj (clk),
      .reset (rst),
      .vga   (b_if)
   );

   typedef struct {
      int         dut;
      int         phase;
      int         cyc;
      logic [9:0] qh;
      logic [9:0] qv;
      logic       tick;
      logic       hs;
      logic       vs;
      logic       von;
      logic       eof;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   int edges  = 0;
   int phase  = 0;
   bit in_rst = 1'b0;

   int a_hs_low = 0, b_vs_low = 0, b_eof = 0, a_eof = 0;
   int a_qh_max = 0, a_qv_max = 0, b_qh_max = 0, b_qv_max = 0;

   task automatic push(input int dut, input int ph, input int c,
                       input int qh, input int qv, input bit t, input bit hs,
                       input bit vs, input bit von, input bit eof,
                       input string name);
      exp_t e;
      e.dut = dut; e.phase = ph; e.cyc = c;
      e.qh = 10'(qh); e.qv = 10'(qv);
      e.tick = t; e.hs = hs; e.vs = vs; e.von = von; e.eof = eof;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Edge counter: restarts on every edge that samples reset high.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         edges = 0;
         if (!in_rst) phase++;
         in_rst = 1'b1;
      end else begin
         edges++;
         in_rst = 1'b0;
      end
   end

   // Monitor: sample away from the active edge, pop matching expectations.
   initial forever begin
      @(negedge clk);
      if (phase > 0) begin
         int cyc;
         cyc = edges + 1;
         for (int i = 0; i < exp_q.size(); ) begin
            if (exp_q[i].phase == phase && exp_q[i].cyc == cyc) begin
               exp_t e;
               logic [9:0] qh, qv;
               logic t, hs, vs, von, eof;
               e = exp_q[i];
               if (e.dut == 0) begin
                  qh = a_if.Qh; qv = a_if.Qv; t = a_if.pixel_tick;
                  hs = a_if.hsync; vs = a_if.vsync; von = a_if.video_on;
                  eof = a_if.end_of_frame;
               end else begin
                  qh = b_if.Qh; qv = b_if.Qv; t = b_if.pixel_tick;
                  hs = b_if.hsync; vs = b_if.vsync; von = b_if.video_on;
                  eof = b_if.end_of_frame;
               end
               n_cmp++;
               if (qh !== e.qh || qv !== e.qv || t !== e.tick || hs !== e.hs ||
                   vs !== e.vs || von !== e.von || eof !== e.eof) begin
                  n_fail++;
                  $display("FAIL %s (ph%0d cyc%0d): got Qh=%0d Qv=%0d tick=%b hs=%b vs=%b von=%b eof=%b expected Qh=%0d Qv=%0d tick=%b hs=%b vs=%b von=%b eof=%b",
                           e.name, e.phase, e.cyc, qh, qv, t, hs, vs, von, eof,
                           e.qh, e.qv, e.tick, e.hs, e.vs, e.von, e.eof);
               end
               exp_q.delete(i);
            end else begin
               i++;
            end
         end
         if (phase == 1) begin
            if (cyc <= 3200 && a_if.hsync === 1'b0) a_hs_low++;
            if (cyc <= 640 && b_if.vsync === 1'b0) b_vs_low++;
            if (cyc <= 1280 && b_if.end_of_frame === 1'b1) b_eof++;
            if (a_if.end_of_frame === 1'b1) a_eof++;
            if (int'(a_if.Qh) > a_qh_max) a_qh_max = int'(a_if.Qh);
            if (int'(a_if.Qv) > a_qv_max) a_qv_max = int'(a_if.Qv);
            if (int'(b_if.Qh) > b_qh_max) b_qh_max = int'(b_if.Qh);
            if (int'(b_if.Qv) > b_qv_max) b_qv_max = int'(b_if.Qv);
         end
      end
   end

   initial begin
      // ---------------- phase 1: full-timing instance ----------------
      //       dut ph cyc   Qh   Qv  tk hs vs von eof
      push(0, 1, 1,    0,   0, 0, 1, 1, 1, 0, "A_reset_state");
      push(0, 1, 3,    0,   0, 0, 1, 1, 1, 0, "A_no_tick_cyc3");
      push(0, 1, 4,    0,   0, 1, 1, 1, 1, 0, "A_first_tick");
      push(0, 1, 5,    1,   0, 0, 1, 1, 1, 0, "A_qh1");
      push(0, 1, 8,    1,   0, 1, 1, 1, 1, 0, "A_second_tick");
      push(0, 1, 9,    2,   0, 0, 1, 1, 1, 0, "A_qh2");
      push(0, 1, 2557, 639, 0, 0, 1, 1, 1, 0, "A_last_visible_px");
      push(0, 1, 2561, 640, 0, 0, 1, 1, 0, 0, "A_first_blank_px");
      push(0, 1, 2624, 655, 0, 1, 1, 1, 0, 0, "A_pre_hsync");
      push(0, 1, 2625, 656, 0, 0, 0, 1, 0, 0, "A_hsync_start");
      push(0, 1, 3008, 751, 0, 1, 0, 1, 0, 0, "A_hsync_last");
      push(0, 1, 3009, 752, 0, 0, 1, 1, 0, 0, "A_hsync_end");
      push(0, 1, 3200, 799, 0, 1, 1, 1, 0, 0, "A_line_end");
      push(0, 1, 3201, 0,   1, 0, 1, 1, 1, 0, "A_line_wrap");
      push(0, 1, 6400, 799, 1, 1, 1, 1, 0, 0, "A_line1_end");
      push(0, 1, 6401, 0,   2, 0, 1, 1, 1, 0, "A_line2_start");
      push(0, 1, 9202, 700, 2, 0, 0, 1, 0, 0, "A_before_midreset");
      // ---------------- phase 1: reduced-raster instance ----------------
      push(1, 1, 1,    0,  0, 0, 1, 1, 1, 0, "B_reset_state");
      push(1, 1, 33,   8,  0, 0, 1, 1, 0, 0, "B_h_blank");
      push(1, 1, 40,   9,  0, 1, 1, 1, 0, 0, "B_pre_hsync");
      push(1, 1, 41,   10, 0, 0, 0, 1, 0, 0, "B_hsync_start");
      push(1, 1, 52,   12, 0, 1, 0, 1, 0, 0, "B_hsync_last");
      push(1, 1, 53,   13, 0, 0, 1, 1, 0, 0, "B_hsync_end");
      push(1, 1, 349,  7,  5, 0, 1, 1, 1, 0, "B_last_visible");
      push(1, 1, 385,  0,  6, 0, 1, 1, 0, 0, "B_v_blank");
      push(1, 1, 448,  15, 6, 1, 1, 1, 0, 0, "B_pre_vsync");
      push(1, 1, 449,  0,  7, 0, 1, 0, 0, 0, "B_vsync_start");
      push(1, 1, 576,  15, 8, 1, 1, 0, 0, 0, "B_vsync_last");
      push(1, 1, 577,  0,  9, 0, 1, 1, 0, 0, "B_vsync_end");
      push(1, 1, 639,  15, 9, 0, 1, 1, 0, 0, "B_pre_eof");
      push(1, 1, 640,  15, 9, 1, 1, 1, 0, 1, "B_eof");
      push(1, 1, 641,  0,  0, 0, 1, 1, 1, 0, "B_frame_wrap");
      push(1, 1, 9202, 12, 3, 0, 0, 1, 0, 0, "B_before_midreset");

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (9201) @(posedge clk);

      // ---------------- phase 2: reset mid-line, inside hsync ----------------
      push(0, 2, 1, 0, 0, 0, 1, 1, 1, 0, "A_after_midreset");
      push(0, 2, 3, 0, 0, 0, 1, 1, 1, 0, "A_restart_no_tick");
      push(0, 2, 4, 0, 0, 1, 1, 1, 1, 0, "A_restart_tick");
      push(0, 2, 5, 1, 0, 0, 1, 1, 1, 0, "A_restart_qh1");
      push(1, 2, 1, 0, 0, 0, 1, 1, 1, 0, "B_after_midreset");
      push(1, 2, 4, 0, 0, 1, 1, 1, 1, 0, "B_restart_tick");
      push(1, 2, 5, 1, 0, 0, 1, 1, 1, 0, "B_restart_qh1");
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      #1;

      check_int("A_hsync_low_cycles_line0", a_hs_low, 384);
      check_int("B_vsync_low_cycles_frame0", b_vs_low, 128);
      check_int("B_eof_pulses_two_frames", b_eof, 2);
      check_int("A_eof_pulses_partial_frame", a_eof, 0);
      check_int("A_qh_max", a_qh_max, 799);
      check_int("A_qv_max", a_qv_max, 2);
      check_int("B_qh_max", b_qh_max, 15);
      check_int("B_qv_max", b_qv_max, 9);

      foreach (exp_q[i]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: sample never reached (ph%0d cyc%0d), expected Qh=%0d Qv=%0d",
                  exp_q[i].name, exp_q[i].phase, exp_q[i].cyc, exp_q[i].qh, exp_q[i].qv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
